// File: rtl/adc_frame_sink_if.sv
// -----------------------------------------------------------------------------
// adc_frame_sink_if
// AXI-Stream style bundle used on both sides of adc_frame_sink.
//   tvalid : beat valid (driven by master)
//   tready : beat accept (driven by slave)
//   tdata  : 64-bit beat, [63:16] sample index, [15:0] payload
//   tlast  : last beat of frame
//   tuser  : frame truncated by overflow (meaningful with tlast)
// -----------------------------------------------------------------------------
interface adc_frame_sink_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic        tlast;
  logic        tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/adc_frame_sink.sv
// -----------------------------------------------------------------------------
// adc_frame_sink
// Receives continuous ADC beat bursts (no upstream back-pressure), splits them
// into frames at every tvalid gap, buffers them in an on-chip FIFO and re-emits
// them as a first-word-fall-through AXI-Stream with tlast and a truncation flag.
// Ports:
//   aclk, areset   : clock, asynchronous active-high reset
//   s_axis         : input stream (tready informational only, low in DROP)
//   m_axis         : output stream (tvalid/tready handshake, tlast, tuser)
//   clear_stats    : synchronous clear of all statistics counters
//   fill_level     : entries written and not yet accepted downstream
//   frames_count   : frames closed (including truncated / fully dropped)
//   trunc_count    : frames truncated or fully dropped
//   overflow_count : input beats discarded
//   gap_count      : in-frame sample-index discontinuities
// -----------------------------------------------------------------------------
module adc_frame_sink #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  aclk,
  input  logic                  areset,
  adc_frame_sink_if.slave       s_axis,
  adc_frame_sink_if.master      m_axis,
  input  logic                  clear_stats,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic [31:0]           frames_count,
  output logic [15:0]           trunc_count,
  output logic [31:0]           overflow_count,
  output logic [31:0]           gap_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FILL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] FILL_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_DROP} state_e;

  state_e                state_q, state_d;
  logic [63:0]           hold_q, hold_d;
  logic                  from_idle_q, from_idle_d;
  logic                  s_ready_q, s_ready_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   fill_q, fill_d;
  logic [31:0]           frames_q, frames_d;
  logic [15:0]           trunc_q, trunc_d;
  logic [31:0]           over_q, over_d;
  logic [31:0]           gap_q, gap_d;

  // Entry layout: {tuser, tlast, tdata}
  logic [65:0]           mem [DEPTH];
  logic [65:0]           rd_entry;
  logic [65:0]           wr_entry;
  logic                  wr_en;
  logic                  pop;
  logic                  inc_frames, inc_trunc, inc_over, inc_gap;
  logic [47:0]           next_idx;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    hold_d      = hold_q;
    from_idle_d = from_idle_q;
    wr_en       = 1'b0;
    wr_entry    = {2'b00, hold_q};
    inc_frames  = 1'b0;
    inc_trunc   = 1'b0;
    inc_over    = 1'b0;
    inc_gap     = 1'b0;
    next_idx    = hold_q[63:16] + 48'd1;

    // All decisions use the registered fill level, before any same-cycle pop.
    unique case (state_q)
      ST_IDLE: begin
        if (s_axis.tvalid) begin
          if (fill_q == FILL_FULL) begin
            inc_over    = 1'b1;
            from_idle_d = 1'b1;
            state_d     = ST_DROP;
          end else begin
            hold_d  = s_axis.tdata;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!s_axis.tvalid) begin
          wr_en      = 1'b1;
          wr_entry   = {1'b0, 1'b1, hold_q};
          inc_frames = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          inc_gap = (s_axis.tdata[63:16] != next_idx);
          if (fill_q == FILL_LAST) begin
            // Held beat takes the last free slot and closes the frame as truncated.
            wr_en       = 1'b1;
            wr_entry    = {1'b1, 1'b1, hold_q};
            inc_over    = 1'b1;
            inc_trunc   = 1'b1;
            from_idle_d = 1'b0;
            state_d     = ST_DROP;
          end else begin
            wr_en    = 1'b1;
            wr_entry = {1'b0, 1'b0, hold_q};
            hold_d   = s_axis.tdata;
          end
        end
      end
      ST_DROP: begin
        if (s_axis.tvalid) begin
          inc_over = 1'b1;
        end else begin
          inc_frames = 1'b1;
          // A frame dropped entirely was never counted as truncated on entry.
          inc_trunc  = from_idle_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    s_ready_d = (state_d != ST_DROP);
    pop       = (fill_q != '0) && m_axis.tready;
    wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(wr_en);
    rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(pop);
    fill_d    = fill_q + (ADDR_WIDTH+1)'(wr_en) - (ADDR_WIDTH+1)'(pop);

    // Saturating counters; clear_stats overrides any same-cycle increment.
    frames_d = clear_stats ? '0 : (inc_frames && !(&frames_q)) ? frames_q + 32'd1 : frames_q;
    trunc_d  = clear_stats ? '0 : (inc_trunc  && !(&trunc_q))  ? trunc_q  + 16'd1 : trunc_q;
    over_d   = clear_stats ? '0 : (inc_over   && !(&over_q))   ? over_q   + 32'd1 : over_q;
    gap_d    = clear_stats ? '0 : (inc_gap    && !(&gap_q))    ? gap_q    + 32'd1 : gap_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      from_idle_q <= 1'b0;
      s_ready_q   <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      frames_q    <= '0;
      trunc_q     <= '0;
      over_q      <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      from_idle_q <= from_idle_d;
      s_ready_q   <= s_ready_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      frames_q    <= frames_d;
      trunc_q     <= trunc_d;
      over_q      <= over_d;
      gap_q       <= gap_d;
    end
  end

  // NOTE: the storage array has no reset; fill level alone defines which entries are live.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

  assign rd_entry = mem[rd_ptr_q];

  // tvalid comes straight from the async-reset fill level, so it drops with reset;
  // sideband bits are gated so stale memory never shows on an idle bus.
  assign m_axis.tvalid  = (fill_q != '0);
  assign m_axis.tdata   = rd_entry[63:0];
  assign m_axis.tlast   = m_axis.tvalid & rd_entry[64];
  assign m_axis.tuser   = m_axis.tvalid & rd_entry[65];
  assign s_axis.tready  = s_ready_q;

  assign fill_level     = fill_q;
  assign frames_count   = frames_q;
  assign trunc_count    = trunc_q;
  assign overflow_count = over_q;
  assign gap_count      = gap_q;

endmodule

// File: doc/adc_frame_sink.md
# adc_frame_sink

Receiving end of the ADC capture stream. Accepts the 64-bit AXI-Stream beats the ADC front-end emits while its trigger is active (continuous `tvalid` bursts, no back-pressure honoured upstream), splits them into frames at every `tvalid` gap, and buffers them in an on-chip FIFO. Re-emits the frames as a standard AXI-Stream with `tready`, `tlast` and a truncation flag. Sits between the ADC block and the DMA/readout logic, and exposes frame, overflow and continuity statistics to the register file.

## Interface
- `ADDR_WIDTH`, default 10, FIFO depth DEPTH = 2^ADDR_WIDTH entries.
- `aclk` input 1 system clock; all logic on rising edge.
- `areset` input 1 reset, asynchronous, active-high.
- `s_axis_tvalid` input 1 upstream beat valid; frame boundary = cycle with `tvalid` low.
- `s_axis_tdata` input 64 upstream beat; [63:16] = 48-bit sample index, [15:0] = payload.
- `s_axis_tready` output 1 high unless state = DROP. Informational only: upstream ignores it.
- `m_axis_tvalid` output 1 output beat valid.
- `m_axis_tready` input 1 downstream accept.
- `m_axis_tdata` output 64 stored beat, unmodified.
- `m_axis_tlast` output 1 last beat of frame.
- `m_axis_tuser` output 1 frame truncated by overflow; valid with `tlast`, 0 elsewhere.
- `clear_stats` input 1 synchronous clear of all statistics counters.
- `fill_level` output ADDR_WIDTH+1 entries written and not yet accepted downstream.
- `frames_count` output 32 frames closed, including truncated and fully dropped frames.
- `trunc_count` output 16 frames truncated or fully dropped.
- `overflow_count` output 32 input beats discarded.
- `gap_count` output 32 in-frame sample-index discontinuities.

## Operation
- Entry format: {tuser, tlast, tdata}, 66 bits. FIFO pointers wrap modulo DEPTH. Full/empty are derived from `fill_level`.
- Hold register: each accepted beat waits one cycle so `tlast` is known when it is written.
- Decisions use the registered `fill_level` (F), sampled before any same-cycle read.
- States:
  - IDLE
    - `tvalid` and F < DEPTH: capture beat into hold; go to HOLD.
    - `tvalid` and F = DEPTH: overflow+1; go to DROP.
  - HOLD
    - `tvalid` low: write hold {0,1,data}; frames+1; go to IDLE.
    - `tvalid` and F < DEPTH-1: write hold {0,0,data}; capture new beat.
    - `tvalid` and F = DEPTH-1: write hold {1,1,data}; overflow+1; trunc+1; go to DROP.
  - DROP
    - `tvalid`: overflow+1.
    - `tvalid` low: frames+1; go to IDLE. If entered from IDLE, trunc+1 here.
- Invariant: in HOLD, F ≤ DEPTH-1. A write is never blocked.
- Gap check in HOLD with `tvalid`: if new[63:16] ≠ hold[63:16]+1 (mod 2^48), then gap_count+1. The frame is not split.
- Counters saturate at all-ones.
- `clear_stats` zeroes all four counters. It wins over a same-cycle increment. It does not touch the FIFO or the state.
- Output side: FWFT.
  - `m_axis_tvalid` = (fill_level ≠ 0).
  - Pop on `m_axis_tvalid` & `m_axis_tready`.
  - `m_axis_*` stable while `tvalid` high and `tready` low.
- Same-cycle write and pop: `fill_level` unchanged.

## Timing
- Reset values: state IDLE, FIFO empty, `fill_level` 0, all counters 0.
- Reset values, stream outputs: `m_axis_tvalid` 0, `tlast` 0, `tuser` 0, `s_axis_tready` 1.
- Beat sampled at edge k is written at edge k+1 and presented on `m_axis` at edge k+2 when the FIFO was empty. Minimum latency is 2 cycles.
- `fill_level` and counters update on the edge of the causing event. Counters are visible one cycle after the triggering input.
- Throughput: 1 beat/cycle in and out sustained.
- Reset asserted mid-frame:
  - Hold and FIFO contents are discarded.
  - `m_axis_tvalid` drops asynchronously.
  - The first beat after release starts a new frame.
- Single-beat frame (`tvalid` high for one cycle) gives one entry with `tlast` = 1.

## Test plan
- Burst of 5 beats, indices 100..104, then `tvalid` low, `m_axis_tready` = 1 → 5 output beats with `tlast` only on index 104; first output 2 cycles after first input; frames_count = 1; gap_count = 0.
- Two bursts of 3 and 1 beats separated by one idle cycle → outputs 3+1 with `tlast` on the 3rd and 4th beats; frames_count = 2.
- ADDR_WIDTH = 3, `m_axis_tready` = 0, one 12-beat burst → FIFO holds 8 entries; the 8th has `tlast` = 1 and `tuser` = 1; overflow_count = 4; trunc_count = 1; `s_axis_tready` low for the rest of the burst. A second burst while full → overflow_count grows by its length; trunc_count = 2; frames_count = 2.
- Burst with indices 10, 11, 13, 14 → gap_count = 1; a single frame of 4 beats.
- `areset` pulse mid-burst, then burst 50..52 → outputs only 50..52; counters restart from 0.
- `clear_stats` asserted on the same cycle a frame closes → frames_count = 0 afterwards.
- Random `m_axis_tready` against a full-rate burst within capacity → no beat lost; output order preserved; `fill_level` returns to 0.
